dspm_pipe_ctrl: RTL and testbench

Pipelined, round-robin D-cache scratchpad (SPM) controller for the std_cache data memories in SPM mode. Arbitrates NR_PORTS dcache request ports onto the NR_WAYS data SRAMs and accepts one request per cycle. Returns read data after a fixed NR_WAIT_STAGES latency while up to NR_WAIT_STAGES requests are in flight. Responses from way-disabled accesses keep the same latency, so per-port response order is preserved.

---
 rtl/dspm_pkg.sv | 55 +++++
 rtl/dspm_resp_pipe.sv | 49 ++++
 rtl/dspm_pipe_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dspm_pipe_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dspm_pkg.sv
// dspm_pkg: shared types and constants for the D-cache scratchpad controller.
//   dcache_req_i_t / dcache_req_o_t : per-port request and response bundles
//   dspm_resp_t                     : one response-pipeline entry
//   SPM_ERR_DATA                    : read data returned for accesses to a disabled way
//   word_offset()                   : XLEN word index of a byte address within a line
package dspm_pkg;

    localparam int XLEN         = 64;
    localparam int LINE_WIDTH   = 128;
    localparam int MEMORY_WIDTH = 172;
    localparam int IDX_WIDTH    = 12;
    localparam int TAG_WIDTH    = MEMORY_WIDTH - LINE_WIDTH;
    localparam int BE_WIDTH     = (MEMORY_WIDTH + 7) / 8;
    localparam int LINE_BYTES   = LINE_WIDTH / 8;
    localparam int WORDS        = LINE_WIDTH / XLEN;
    localparam int WOFF_W       = $clog2(WORDS);
    localparam int BYTE_OFF_W   = $clog2(LINE_BYTES);
    localparam int XLEN_OFF_W   = $clog2(XLEN / 8);

    // Port and way fields in a pipeline entry are sized for up to 16 of each.
    localparam int PORT_IDX_W   = 4;
    localparam int WAY_IDX_W    = 4;

    localparam logic [XLEN-1:0] SPM_ERR_DATA = 64'hCA11AB1E_BADCAB1E;

    typedef struct packed {
        logic [IDX_WIDTH-1:0] address_index;
        logic [TAG_WIDTH-1:0] address_tag;
        logic [XLEN-1:0]      data_wdata;
        logic [XLEN/8-1:0]    data_be;
        logic                 data_we;
        logic                 data_req;
        logic                 kill_req;
    } dcache_req_i_t;

    typedef struct packed {
        logic            data_gnt;
        logic            data_rvalid;
        logic [XLEN-1:0] data_rdata;
    } dcache_req_o_t;

    typedef struct packed {
        logic                  valid;
        logic [PORT_IDX_W-1:0] port;
        logic [WAY_IDX_W-1:0]  way;
        logic [WOFF_W-1:0]     woff;
        logic                  is_read;
        logic                  err;
    } dspm_resp_t;

    function automatic logic [WOFF_W-1:0] word_offset(input logic [IDX_WIDTH-1:0] addr);
        return addr[BYTE_OFF_W-1:XLEN_OFF_W];
    endfunction

endpackage

// File: rtl/dspm_resp_pipe.sv
// dspm_resp_pipe: fixed-latency shift register of response entries.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_entry        : entry captured every cycle (valid=0 when nothing was accepted)
//   i_kill         : per-port kill; clears is_read of that port's stored entries
//   o_last         : entry in the final stage, due for response this cycle
module dspm_resp_pipe
    import dspm_pkg::*;
#(
    parameter int NR_STAGES = 1,
    parameter int NR_PORTS  = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  dspm_resp_t          i_entry,
    input  logic [NR_PORTS-1:0] i_kill,
    output dspm_resp_t          o_last
);

    dspm_resp_t r_stage [NR_STAGES];

    // A killed entry still travels the pipe (the SRAM read completes) but
    // will not raise rvalid when it reaches the last stage.
    function automatic dspm_resp_t apply_kill(input dspm_resp_t e, input logic [NR_PORTS-1:0] kill);
        dspm_resp_t r;
        r = e;
        for (int p = 0; p < NR_PORTS; p++) begin
            if (kill[p] && (e.port == PORT_IDX_W'(p))) begin
                r.is_read = 1'b0;
            end
        end
        return r;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NR_STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_entry;
            for (int i = 1; i < NR_STAGES; i++) begin
                r_stage[i] <= apply_kill(r_stage[i-1], i_kill);
            end
        end
    end

    assign o_last = r_stage[NR_STAGES-1];

endmodule

// File: rtl/dspm_pipe_ctrl.sv
// dspm_pipe_ctrl: pipelined scratchpad controller over the data SRAM ways.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   active_ways_i    : ways usable as scratchpad
//   spm_req_ports_i  : request ports; spm_req_ports_o : gnt / rvalid / rdata
//   req_o, addr_o, wdata_o, we_o, be_o : SRAM access of the granted request
//   rdata_i          : SRAM read data, NR_WAIT_STAGES cycles after req_o
// Handshake: a port holds data_req with its payload; data_gnt in the same
// cycle means the request was taken. Responses have no backpressure:
// data_rvalid is a one-cycle pulse exactly NR_WAIT_STAGES cycles after the
// grant of a read. One request is accepted per cycle, never stalled.
module dspm_pipe_ctrl
    import dspm_pkg::*;
#(
    parameter int NR_PORTS       = 3,
    parameter int NR_WAYS        = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int NR_WAIT_STAGES = 1,
    parameter int RR_FAIR        = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NR_WAYS-1:0]      active_ways_i,
    input  dcache_req_i_t           spm_req_ports_i [NR_PORTS],
    output dcache_req_o_t           spm_req_ports_o [NR_PORTS],
    output logic [NR_WAYS-1:0]      req_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [MEMORY_WIDTH-1:0] wdata_o,
    output logic                    we_o,
    output logic [BE_WIDTH-1:0]     be_o,
    input  logic [MEMORY_WIDTH-1:0] rdata_i [NR_WAYS]
);

    localparam int PORT_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int WAY_W  = $clog2(NR_WAYS);

    logic [PORT_W-1:0]   r_rr_ptr;
    logic [NR_PORTS-1:0] w_req_vec;
    logic [NR_PORTS-1:0] w_kill_vec;
    logic [PORT_W-1:0]   w_cand;
    logic [PORT_W-1:0]   w_win;
    logic                w_found;
    dcache_req_i_t       w_sel;
    logic [WAY_W-1:0]    w_way;
    logic [WOFF_W-1:0]   w_woff;
    logic                w_way_on;
    dspm_resp_t          w_push;
    dspm_resp_t          w_last;
    logic [LINE_WIDTH-1:0] w_line;
    logic [XLEN-1:0]     w_word;
    logic [XLEN-1:0]     w_rdata;
    logic                w_unused_bits;

    // Arbitration: scan ports starting at the RR pointer (or 0 for fixed
    // priority); first requester wins. Requests are masked by reset so every
    // output is quiet while rst_ni is low.
    always_comb begin
        w_req_vec  = '0;
        w_kill_vec = '0;
        w_found    = 1'b0;
        w_win      = '0;
        w_cand     = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            w_req_vec[p]  = rst_ni & spm_req_ports_i[p].data_req;
            w_kill_vec[p] = spm_req_ports_i[p].kill_req;
        end
        for (int k = 0; k < NR_PORTS; k++) begin
            w_cand = PORT_W'((((RR_FAIR != 0) ? int'(r_rr_ptr) : 0) + k) % NR_PORTS);
            if (!w_found && w_req_vec[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_comb begin
        w_sel = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            if (w_win == PORT_W'(p)) begin
                w_sel = spm_req_ports_i[p];
            end
        end
    end

    assign w_way    = w_sel.address_tag[WAY_W-1:0];
    assign w_woff   = word_offset(w_sel.address_index);
    assign w_way_on = active_ways_i[w_way];

    // SRAM side. Writes also set every tag/status byte enable so the tag
    // field is overwritten with zeros.
    always_comb begin
        req_o   = '0;
        addr_o  = '0;
        wdata_o = '0;
        we_o    = 1'b0;
        be_o    = '0;
        if (w_found) begin
            addr_o = ADDR_WIDTH'(w_sel.address_index);
            if (w_way_on) begin
                req_o[w_way] = 1'b1;
                we_o         = w_sel.data_we;
                if (w_sel.data_we) begin
                    be_o[BE_WIDTH-1:LINE_BYTES] = '1;
                    for (int o = 0; o < WORDS; o++) begin
                        if (w_woff == WOFF_W'(o)) begin
                            be_o[o*XLEN/8 +: XLEN/8] = w_sel.data_be;
                            wdata_o[o*XLEN +: XLEN]  = w_sel.data_wdata;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        w_push         = '0;
        w_push.valid   = w_found;
        w_push.port    = PORT_IDX_W'(w_win);
        w_push.way     = WAY_IDX_W'(w_way);
        w_push.woff    = w_woff;
        w_push.is_read = ~w_sel.data_we;
        w_push.err     = ~w_way_on;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= (w_win == PORT_W'(NR_PORTS - 1)) ? '0 : w_win + PORT_W'(1);
        end
    end

    dspm_resp_pipe #(
        .NR_STAGES (NR_WAIT_STAGES),
        .NR_PORTS  (NR_PORTS)
    ) u_resp_pipe (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_entry (w_push),
        .i_kill  (w_kill_vec),
        .o_last  (w_last)
    );

    always_comb begin
        w_line = '0;
        for (int w = 0; w < NR_WAYS; w++) begin
            if (w_last.way == WAY_IDX_W'(w)) begin
                w_line = rdata_i[w][LINE_WIDTH-1:0];
            end
        end
        w_word = '0;
        for (int o = 0; o < WORDS; o++) begin
            if (w_last.woff == WOFF_W'(o)) begin
                w_word = w_line[o*XLEN +: XLEN];
            end
        end
        w_rdata = w_last.err ? SPM_ERR_DATA : w_word;
    end

    always_comb begin
        for (int p = 0; p < NR_PORTS; p++) begin
            spm_req_ports_o[p]          = '0;
            spm_req_ports_o[p].data_gnt = w_found && (w_win == PORT_W'(p));
            if (rst_ni && w_last.valid && w_last.is_read && (w_last.port == PORT_IDX_W'(p))) begin
                spm_req_ports_o[p].data_rvalid = 1'b1;
                spm_req_ports_o[p].data_rdata  = w_rdata;
            end
        end
    end

    // Upper tag bits and SRAM tag/status read bits carry no information here.
    always_comb begin
        w_unused_bits = 1'b0;
        for (int p = 0; p < NR_PORTS; p++) begin
            w_unused_bits = w_unused_bits ^ (^spm_req_ports_i[p].address_tag[TAG_WIDTH-1:WAY_W]);
        end
        for (int w = 0; w < NR_WAYS; w++) begin
            w_unused_bits = w_unused_bits ^ (^rdata_i[w][MEMORY_WIDTH-1:LINE_WIDTH]);
        end
    end

endmodule

// File: tb/tb_dspm_pipe_ctrl.sv
module tb_dspm_pipe_ctrl;
    import dspm_pkg::*;

    localparam int CW = 176;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] active_ways = 4'b1111;
    dcache_req_i_t ports_i [3];
    dcache_req_o_t po_a [3];
    dcache_req_o_t po_b [3];
    logic [3:0]   req_a, req_b;
    logic [63:0]  addr_a, addr_b;
    logic [171:0] wd_a, wd_b;
    logic         we_a, we_b;
    logic [21:0]  be_a, be_b;
    logic [171:0] rdata [4];
    logic [2:0]   gnt_a, gnt_b, rv_a;

    int n_vec = 0;
    int n_err = 0;

    // Contention schedule: grant order 0,1,2,0 and matching responses two cycles later.
    logic [2:0]  ct_gnt  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000};
    logic [3:0]  ct_req  [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0000, 4'b0000};
    logic [2:0]  ct_rv   [6] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
    int          ct_port [6] = '{0, 0, 0, 1, 2, 0};
    logic [63:0] ct_data [6] = '{64'h0, 64'h0, 64'hD0D0_0000_0000_0000, 64'hD0D0_0000_0000_0011,
                                 64'hD0D0_0000_0000_0030, 64'hD0D0_0000_0000_0000};

    always #5 clk = ~clk;

    dspm_pipe_ctrl #(.NR_PORTS(3), .NR_WAYS(4), .ADDR_WIDTH(64), .NR_WAIT_STAGES(2), .RR_FAIR(1)) u_dut_rr (
        .clk_i(clk), .rst_ni(rst_n), .active_ways_i(active_ways),
        .spm_req_ports_i(ports_i), .spm_req_ports_o(po_a),
        .req_o(req_a), .addr_o(addr_a), .wdata_o(wd_a), .we_o(we_a), .be_o(be_a), .rdata_i(rdata)
    );

    dspm_pipe_ctrl #(.NR_PORTS(3), .NR_WAYS(4), .ADDR_WIDTH(64), .NR_WAIT_STAGES(2), .RR_FAIR(0)) u_dut_fp (
        .clk_i(clk), .rst_ni(rst_n), .active_ways_i(active_ways),
        .spm_req_ports_i(ports_i), .spm_req_ports_o(po_b),
        .req_o(req_b), .addr_o(addr_b), .wdata_o(wd_b), .we_o(we_b), .be_o(be_b), .rdata_i(rdata)
    );

    assign gnt_a = {po_a[2].data_gnt, po_a[1].data_gnt, po_a[0].data_gnt};
    assign gnt_b = {po_b[2].data_gnt, po_b[1].data_gnt, po_b[0].data_gnt};
    assign rv_a  = {po_a[2].data_rvalid, po_a[1].data_rvalid, po_a[0].data_rvalid};

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clr_req();
        for (int p = 0; p < 3; p++) ports_i[p] = '0;
    endtask

    task automatic set_req(input int p, input logic [11:0] idx, input logic [43:0] tag,
                           input logic we, input logic [7:0] be, input logic [63:0] wd);
        ports_i[p].address_index = idx;
        ports_i[p].address_tag   = tag;
        ports_i[p].data_we       = we;
        ports_i[p].data_be       = be;
        ports_i[p].data_wdata    = wd;
        ports_i[p].data_req      = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rdata[0] = {44'h0, 64'hD0D0_0000_0000_0001, 64'hD0D0_0000_0000_0000};
        rdata[1] = {44'h0, 64'hD0D0_0000_0000_0011, 64'hD0D0_0000_0000_0010};
        rdata[2] = {44'h0, 64'hD0D0_0000_0000_0021, 64'hD0D0_0000_0000_0020};
        rdata[3] = {44'h0, 64'hD0D0_0000_0000_0031, 64'hD0D0_0000_0000_0030};
        clr_req();

        // Reset state, with a request presented to prove outputs stay quiet.
        set_req(0, 12'h008, 44'h1, 1'b1, 8'hFF, 64'h55);
        @(negedge clk);
        chk("rst_gnt", CW'(gnt_a), CW'(3'b000));
        chk("rst_rvalid", CW'(rv_a), CW'(3'b000));
        chk("rst_req_o", CW'(req_a), CW'(4'b0000));
        chk("rst_addr", CW'(addr_a), CW'(64'h0));
        chk("rst_we_be", CW'({we_a, be_a}), CW'(23'h0));
        chk("rst_wdata", CW'(wd_a), CW'(172'h0));
        next_cycle();
        clr_req();
        rst_n = 1'b1;

        // Contention: all three ports read for four cycles.
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            clr_req();
            if (c < 4) begin
                set_req(0, 12'h000, 44'h0, 1'b0, 8'h00, 64'h0);
                set_req(1, 12'h008, 44'h1, 1'b0, 8'h00, 64'h0);
                set_req(2, 12'h010, 44'h3, 1'b0, 8'h00, 64'h0);
            end
            @(negedge clk);
            chk("rr_gnt", CW'(gnt_a), CW'(ct_gnt[c]));
            chk("fp_gnt", CW'(gnt_b), CW'((c < 4) ? 3'b001 : 3'b000));
            chk("rr_req_o", CW'(req_a), CW'(ct_req[c]));
            chk("rr_rvalid", CW'(rv_a), CW'(ct_rv[c]));
            if (ct_rv[c] != 3'b000) chk("rr_rdata", CW'(po_a[ct_port[c]].data_rdata), CW'(ct_data[c]));
        end

        // Single read: port1, way 2, index 0x48 (upper word).
        next_cycle();
        clr_req();
        set_req(1, 12'h048, 44'h2, 1'b0, 8'h00, 64'h0);
        @(negedge clk);
        chk("rd_gnt", CW'(gnt_a), CW'(3'b010));
        chk("rd_req_o", CW'(req_a), CW'(4'b0100));
        chk("rd_addr", CW'(addr_a), CW'(64'h48));
        chk("rd_we_be", CW'({we_a, be_a}), CW'(23'h0));
        next_cycle();
        clr_req();
        @(negedge clk);
        chk("rd_rvalid_c1", CW'(rv_a), CW'(3'b000));
        next_cycle();
        @(negedge clk);
        chk("rd_rvalid_c2", CW'(rv_a), CW'(3'b010));
        chk("rd_rdata", CW'(po_a[1].data_rdata), CW'(64'hD0D0_0000_0000_0021));

        // Write: port0, way 0, word 1, be F0.
        next_cycle();
        set_req(0, 12'h008, 44'h0, 1'b1, 8'hF0, 64'h1122334455667788);
        @(negedge clk);
        chk("wr_gnt", CW'(gnt_a), CW'(3'b001));
        chk("wr_req_o", CW'(req_a), CW'(4'b0001));
        chk("wr_we", CW'(we_a), CW'(1'b1));
        chk("wr_be", CW'(be_a), CW'(22'h3FF000));
        chk("wr_wdata", CW'(wd_a), CW'({44'h0, 64'h1122334455667788, 64'h0}));
        next_cycle();
        clr_req();
        @(negedge clk);
        chk("wr_rvalid_c1", CW'(rv_a), CW'(3'b000));
        next_cycle();
        @(negedge clk);
        chk("wr_rvalid_c2", CW'(rv_a), CW'(3'b000));

        // Disabled way 0: read returns the error word, write is swallowed.
        next_cycle();
        active_ways = 4'b1110;
        set_req(2, 12'h000, 44'h0, 1'b0, 8'h00, 64'h0);
        @(negedge clk);
        chk("dis_rd_gnt", CW'(gnt_a), CW'(3'b100));
        chk("dis_rd_req_o", CW'({req_a, we_a}), CW'(5'b0));
        next_cycle();
        clr_req();
        set_req(0, 12'h000, 44'h0, 1'b1, 8'hFF, 64'hDEAD);
        @(negedge clk);
        chk("dis_wr_gnt", CW'(gnt_a), CW'(3'b001));
        chk("dis_wr_sram", CW'({req_a, we_a, be_a}), CW'(27'h0));
        next_cycle();
        clr_req();
        @(negedge clk);
        chk("dis_rvalid", CW'(rv_a), CW'(3'b100));
        chk("dis_rdata", CW'(po_a[2].data_rdata), CW'(64'hCA11AB1E_BADCAB1E));
        next_cycle();
        @(negedge clk);
        chk("dis_wr_rvalid", CW'(rv_a), CW'(3'b000));
        active_ways = 4'b1111;

        // Kill: port2 read killed the next cycle, port1 read in the same window survives.
        next_cycle();
        set_req(2, 12'h008, 44'h3, 1'b0, 8'h00, 64'h0);
        @(negedge clk);
        chk("kill_gnt2", CW'(gnt_a), CW'(3'b100));
        next_cycle();
        clr_req();
        ports_i[2].kill_req = 1'b1;
        set_req(1, 12'h000, 44'h1, 1'b0, 8'h00, 64'h0);
        @(negedge clk);
        chk("kill_gnt1", CW'(gnt_a), CW'(3'b010));
        next_cycle();
        clr_req();
        @(negedge clk);
        chk("kill_rvalid_c2", CW'(rv_a), CW'(3'b000));
        next_cycle();
        @(negedge clk);
        chk("kill_rvalid_c3", CW'(rv_a), CW'(3'b010));
        chk("kill_rdata", CW'(po_a[1].data_rdata), CW'(64'hD0D0_0000_0000_0010));

        // Reset with two reads in flight.
        next_cycle();
        set_req(0, 12'h000, 44'h0, 1'b0, 8'h00, 64'h0);
        @(negedge clk);
        chk("mrst_gnt0", CW'(gnt_a), CW'(3'b001));
        next_cycle();
        clr_req();
        set_req(1, 12'h000, 44'h1, 1'b0, 8'h00, 64'h0);
        @(negedge clk);
        chk("mrst_gnt1", CW'(gnt_a), CW'(3'b010));
        next_cycle();
        clr_req();
        set_req(0, 12'h000, 44'h0, 1'b0, 8'h00, 64'h0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_gnt", CW'({gnt_a, gnt_b}), CW'(6'b0));
        chk("mrst_rvalid", CW'(rv_a), CW'(3'b000));
        chk("mrst_sram", CW'({req_a, we_a, be_a, addr_a}), CW'(91'h0));
        next_cycle();
        clr_req();
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_rvalid", CW'(rv_a), CW'(3'b000));
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
